// File: rtl/alu_op_sequencer.sv
// Issue/retire stage around a 32-bit combinational ALU: FIFO-buffered requests, one-cycle capture, out_valid/out_ready retire.
// Stall on !out_ready holds out_* and head; in_ready = !full. Optional counters under ALU_SEQ_STATS_EN.
module alu_op_sequencer #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_src1,
  input  logic [31:0]      in_src2,
  input  logic [3:0]       in_alu_ctrl,
  input  logic [2:0]       in_bonus_ctrl,
  input  logic [TAG_W-1:0] in_tag,
  output logic             alu_rst_n,
  output logic [31:0]      alu_src1,
  output logic [31:0]      alu_src2,
  output logic [3:0]       alu_ctrl,
  output logic [2:0]       alu_bonus,
  input  logic [31:0]      alu_result,
  input  logic             alu_zero,
  input  logic             alu_cout,
  input  logic             alu_overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic             out_zero,
  output logic             out_cout,
  output logic             out_overflow,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag,
  output logic             sticky_ovf,
  input  logic             clr_sticky
`ifdef ALU_SEQ_STATS_EN
  ,
  output logic [31:0]      op_count,
  output logic [15:0]      ovf_count
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0]      src1;
    logic [31:0]      src2;
    logic [3:0]       ctrl;
    logic [2:0]       bonus;
    logic [TAG_W-1:0] tag;
  } entry_t;

  function automatic logic is_legal(input logic [3:0] code);
    case (code)
      4'b0000, 4'b0001, 4'b0010, 4'b0110,
      4'b0111, 4'b1100, 4'b1101: is_legal = 1'b1;
      default:                   is_legal = 1'b0;
    endcase
  endfunction

  entry_t           mem [DEPTH];
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             not_empty;
  logic             push;
  logic             capture;
  logic             head_legal;
  logic             ovf_set;

  assign not_empty  = (count != '0);
  assign in_ready   = (count != CNT_W'(DEPTH));
  assign push       = in_valid && in_ready;
  assign capture    = not_empty && (!out_valid || out_ready) && alu_rst_n;
  assign head       = mem[rd_ptr];
  assign head_legal = is_legal(head.ctrl);
  assign ovf_set    = capture && head_legal && alu_overflow;

  // Zero the ALU inputs when idle so nothing stale reaches the datapath.
  assign alu_src1  = not_empty ? head.src1  : '0;
  assign alu_src2  = not_empty ? head.src2  : '0;
  assign alu_ctrl  = not_empty ? head.ctrl  : '0;
  assign alu_bonus = not_empty ? head.bonus : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{src1: in_src1, src2: in_src2, ctrl: in_alu_ctrl,
                       bonus: in_bonus_ctrl, tag: in_tag};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      alu_rst_n    <= 1'b0;
      out_valid    <= 1'b0;
      out_result   <= '0;
      out_zero     <= 1'b0;
      out_cout     <= 1'b0;
      out_overflow <= 1'b0;
      out_illegal  <= 1'b0;
      out_tag      <= '0;
      sticky_ovf   <= 1'b0;
    end else begin
      alu_rst_n <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (capture) rd_ptr <= rd_ptr + 1'b1;
      case ({push, capture})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (capture) begin
        out_valid    <= 1'b1;
        out_illegal  <= !head_legal;
        out_result   <= head_legal ? alu_result : '0;
        out_zero     <= head_legal && alu_zero;
        out_cout     <= head_legal && alu_cout;
        out_overflow <= head_legal && alu_overflow;
        out_tag      <= head.tag;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (ovf_set) sticky_ovf <= 1'b1;
      else if (clr_sticky) sticky_ovf <= 1'b0;
    end
  end

`ifdef ALU_SEQ_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_count  <= '0;
      ovf_count <= '0;
    end else begin
      if (capture) op_count <= op_count + 1'b1;
      else if (clr_sticky) op_count <= '0;
      // Saturated counter still counts as "incremented", so clear loses.
      if (ovf_set) begin
        if (ovf_count != 16'hFFFF) ovf_count <= ovf_count + 1'b1;
      end else if (clr_sticky) begin
        ovf_count <= '0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU hooked to the alu_* ports.
module tb_alu_op_sequencer;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n, in_valid, in_ready, alu_rst_n;
  logic [31:0]      in_src1, in_src2, alu_src1, alu_src2, alu_result, out_result;
  logic [3:0]       in_alu_ctrl, alu_ctrl;
  logic [2:0]       in_bonus_ctrl, alu_bonus;
  logic [TAG_W-1:0] in_tag, out_tag;
  logic             alu_zero, alu_cout, alu_overflow;
  logic             out_valid, out_ready, out_zero, out_cout, out_overflow, out_illegal;
  logic             sticky_ovf, clr_sticky;
`ifdef ALU_SEQ_STATS_EN
  logic [31:0]      op_count;
  logic [15:0]      ovf_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  alu_op_sequencer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_src1(in_src1), .in_src2(in_src2), .in_alu_ctrl(in_alu_ctrl),
    .in_bonus_ctrl(in_bonus_ctrl), .in_tag(in_tag),
    .alu_rst_n(alu_rst_n), .alu_src1(alu_src1), .alu_src2(alu_src2),
    .alu_ctrl(alu_ctrl), .alu_bonus(alu_bonus),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_cout(alu_cout),
    .alu_overflow(alu_overflow),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_cout(out_cout), .out_overflow(out_overflow),
    .out_illegal(out_illegal), .out_tag(out_tag),
    .sticky_ovf(sticky_ovf), .clr_sticky(clr_sticky)
`ifdef ALU_SEQ_STATS_EN
    , .op_count(op_count), .ovf_count(ovf_count)
`endif
  );

  // Behavioural ALU; unknown codes return junk with every flag raised.
  logic [32:0] add_s, sub_s;
  logic        junk;
  assign add_s = {1'b0, alu_src1} + {1'b0, alu_src2};
  assign sub_s = {1'b0, alu_src1} + {1'b0, ~alu_src2} + 33'd1;

  always_comb begin
    alu_result   = '0;
    alu_cout     = 1'b0;
    alu_overflow = 1'b0;
    junk         = 1'b0;
    case (alu_ctrl)
      4'b0000: alu_result = alu_src1 & alu_src2;
      4'b0001: alu_result = alu_src1 | alu_src2;
      4'b0010: begin
        alu_result   = add_s[31:0];
        alu_cout     = add_s[32];
        alu_overflow = (alu_src1[31] == alu_src2[31]) && (add_s[31] != alu_src1[31]);
      end
      4'b0110: begin
        alu_result   = sub_s[31:0];
        alu_cout     = sub_s[32];
        alu_overflow = (alu_src1[31] != alu_src2[31]) && (sub_s[31] != alu_src1[31]);
      end
      4'b0111: alu_result = {31'd0, $signed(alu_src1) < $signed(alu_src2)};
      4'b1100: alu_result = ~(alu_src1 | alu_src2);
      4'b1101: alu_result = ~(alu_src1 & alu_src2);
      default: begin
        alu_result   = 32'hDEADBEEF;
        alu_cout     = 1'b1;
        alu_overflow = 1'b1;
        junk         = 1'b1;
      end
    endcase
    alu_zero = (alu_result == 32'd0) || junk;
  end

  typedef struct {
    logic [3:0]       ctrl;
    logic [31:0]      src1;
    logic [31:0]      src2;
    logic [TAG_W-1:0] tag;
    logic             clr;
    logic [31:0]      res;
    logic             z;
    logic             c;
    logic             o;
    logic             ill;
    logic             sticky;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic vld, input logic [3:0] ctrl, input logic [31:0] a,
                       input logic [31:0] b, input logic [TAG_W-1:0] tag);
    in_valid    = vld;
    in_alu_ctrl = ctrl;
    in_src1     = a;
    in_src2     = b;
    in_tag      = tag;
  endtask

  initial begin
    vecs[0] = '{4'b0010, 32'h7FFFFFFF, 32'h00000001, 4'd3,  1'b0, 32'h80000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{4'b0110, 32'h00000005, 32'h00000005, 4'd1,  1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 4'd2,  1'b1, 32'hF000F000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{4'b0001, 32'h12340000, 32'h00005678, 4'd4,  1'b0, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{4'b1100, 32'h00000000, 32'h00000000, 4'd5,  1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{4'b1101, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd6,  1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{4'b0111, 32'hFFFFFFFF, 32'h00000001, 4'd7,  1'b0, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{4'b0011, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd8,  1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{4'b0010, 32'hFFFFFFFF, 32'h00000001, 4'd9,  1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{4'b0110, 32'h80000000, 32'h00000001, 4'd10, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    rst_n = 1'b0; out_ready = 1'b0; clr_sticky = 1'b0; in_bonus_ctrl = 3'd5;
    drive(1'b0, 4'd0, 32'd0, 32'd0, '0);
    step(); step();
    check("rst out_valid",  64'(out_valid), 64'(0));
    check("rst in_ready",   64'(in_ready), 64'(1));
    check("rst alu_rst_n",  64'(alu_rst_n), 64'(0));
    check("rst sticky",     64'(sticky_ovf), 64'(0));
    check("rst out_result", 64'(out_result), 64'(0));
    check("rst out_tag",    64'(out_tag), 64'(0));
    check("rst alu_src1",   64'(alu_src1), 64'(0));
    rst_n = 1'b1;
    step();
    check("alu_rst_n release", 64'(alu_rst_n), 64'(1));

    // Single-op vectors: push, check head at ALU, capture one edge later.
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, vecs[i].ctrl, vecs[i].src1, vecs[i].src2, vecs[i].tag);
      clr_sticky = vecs[i].clr;
      step();
      in_valid = 1'b0; clr_sticky = 1'b0;
      check($sformatf("v%0d alu_ctrl", i), 64'(alu_ctrl), 64'(vecs[i].ctrl));
      check($sformatf("v%0d alu_src1", i), 64'(alu_src1), 64'(vecs[i].src1));
      check($sformatf("v%0d alu_bonus", i), 64'(alu_bonus), 64'(3'd5));
      check($sformatf("v%0d not yet valid", i), 64'(out_valid), 64'(0));
      step();
      check($sformatf("v%0d out_valid", i), 64'(out_valid), 64'(1));
      check($sformatf("v%0d result", i), 64'(out_result), 64'(vecs[i].res));
      check($sformatf("v%0d zero", i), 64'(out_zero), 64'(vecs[i].z));
      check($sformatf("v%0d cout", i), 64'(out_cout), 64'(vecs[i].c));
      check($sformatf("v%0d ovf", i), 64'(out_overflow), 64'(vecs[i].o));
      check($sformatf("v%0d illegal", i), 64'(out_illegal), 64'(vecs[i].ill));
      check($sformatf("v%0d tag", i), 64'(out_tag), 64'(vecs[i].tag));
      check($sformatf("v%0d sticky", i), 64'(sticky_ovf), 64'(vecs[i].sticky));
    end
    step();
    check("retire idle", 64'(out_valid), 64'(0));

    // Backpressure: op0 to output register, ops 1..4 fill the FIFO.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 4'b0010, 32'(i * 10), 32'd1, TAG_W'(i));
      step();
    end
    drive(1'b1, 4'b0010, 32'd500, 32'd1, 4'd15);
    check("full in_ready", 64'(in_ready), 64'(0));
    check("bp out_valid", 64'(out_valid), 64'(1));
    check("bp out_tag", 64'(out_tag), 64'(0));
    step();
    check("hold out_tag", 64'(out_tag), 64'(0));
    check("hold out_result", 64'(out_result), 64'(1));
    check("hold head", 64'(alu_src1), 64'(10));
    check("hold full", 64'(in_ready), 64'(0));
    in_valid = 1'b0; out_ready = 1'b1;
    for (int j = 1; j < 5; j++) begin
      step();
      check($sformatf("drain%0d valid", j), 64'(out_valid), 64'(1));
      check($sformatf("drain%0d tag", j), 64'(out_tag), 64'(j));
      check($sformatf("drain%0d result", j), 64'(out_result), 64'(j * 10 + 1));
    end
    step();
    check("drain end valid", 64'(out_valid), 64'(0));
    check("drain end in_ready", 64'(in_ready), 64'(1));

    // Reset with work in flight discards everything.
    out_ready = 1'b0;
    for (int i = 1; i < 4; i++) begin
      drive(1'b1, 4'b0010, 32'(i), 32'(i), TAG_W'(i));
      step();
    end
    in_valid = 1'b0;
    check("pre-rst valid", 64'(out_valid), 64'(1));
    rst_n = 1'b0;
    step();
    check("midrst out_valid", 64'(out_valid), 64'(0));
    check("midrst in_ready", 64'(in_ready), 64'(1));
    check("midrst alu_src1", 64'(alu_src1), 64'(0));
    check("midrst alu_rst_n", 64'(alu_rst_n), 64'(0));
    check("midrst sticky", 64'(sticky_ovf), 64'(0));
    rst_n = 1'b1;
    step();
    check("midrst alu_rst_n back", 64'(alu_rst_n), 64'(1));
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("post-rst idle%0d", i), 64'(out_valid), 64'(0));
    end

    // Back-to-back stream: one retire per cycle, two overflowing ADDs.
    for (int i = 0; i < 10; i++) begin
      if (i == 3 || i == 7) drive(1'b1, 4'b0010, 32'h7FFFFFFF, 32'd1, TAG_W'(i));
      else                  drive(1'b1, 4'b0010, 32'(i), 32'(i), TAG_W'(i));
      step();
      if (i > 0) begin
        check($sformatf("stream%0d valid", i), 64'(out_valid), 64'(1));
        check($sformatf("stream%0d tag", i), 64'(out_tag), 64'(i - 1));
      end
    end
    in_valid = 1'b0;
    step();
    check("stream last tag", 64'(out_tag), 64'(9));
    check("stream last result", 64'(out_result), 64'(18));
    check("stream sticky", 64'(sticky_ovf), 64'(1));
`ifdef ALU_SEQ_STATS_EN
    check("op_count", 64'(op_count), 64'(10));
    check("ovf_count", 64'(ovf_count), 64'(2));
    clr_sticky = 1'b1;
    step();
    clr_sticky = 1'b0;
    check("op_count clr", 64'(op_count), 64'(0));
    check("ovf_count clr", 64'(ovf_count), 64'(0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Issue/retire stage wrapped around the 32-bit combinational ALU.
- Buffers operation requests in a small FIFO and presents the head entry to the ALU operand/control inputs.
- Captures the ALU result and flags into a registered output with a valid/ready handshake.
- Tracks a sticky overflow status and flags illegal ALU control codes.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- TAG_W, 4, width of the caller tag carried alongside each operation.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  request valid.
- in_ready  out  1  FIFO can accept; equals (count != DEPTH); no combinational path from out_ready.
- in_src1  in  32  operand A.
- in_src2  in  32  operand B.
- in_alu_ctrl  in  4  ALU control code.
- in_bonus_ctrl  in  3  compare-select code.
- in_tag  in  TAG_W  caller tag.
- alu_rst_n  out  1  to ALU rst_n; registered, 0 during reset, 1 after.
- alu_src1  out  32  head src1; 0 when FIFO empty.
- alu_src2  out  32  head src2; 0 when FIFO empty.
- alu_ctrl  out  4  head alu_ctrl; 0 when FIFO empty.
- alu_bonus  out  3  head bonus_ctrl; 0 when FIFO empty.
- alu_result  in  32  ALU result.
- alu_zero  in  1  ALU zero flag.
- alu_cout  in  1  ALU carry flag.
- alu_overflow  in  1  ALU overflow flag.
- out_valid  out  1  retired result valid.
- out_ready  in  1  consumer accepts.
- out_result  out  32  captured result.
- out_zero  out  1  captured zero flag.
- out_cout  out  1  captured carry flag.
- out_overflow  out  1  captured overflow flag.
- out_illegal  out  1  entry had an illegal alu_ctrl.
- out_tag  out  TAG_W  tag of the retired entry.
- sticky_ovf  out  1  set by any retired op with overflow.
- clr_sticky  in  1  clears sticky_ovf.

Behaviour:
- Reset (rst_n=0 at edge):
  - FIFO pointers and count reset to 0.
  - out_valid, out_illegal, out_zero, out_cout, out_overflow, sticky_ovf reset to 0.
  - out_result and out_tag reset to 0.
  - alu_rst_n reset to 0, then 1 at the first edge with rst_n=1.
  - Reset mid-operation discards all queued and held entries; nothing is retired.
- Push: on in_valid && in_ready, write the entry at wr_ptr, advance it, and increment count.
- ALU drive: while count>0, the head entry drives the alu_* outputs combinationally from FIFO storage. The ALU settles within the cycle.
- Capture condition: count>0 && (!out_valid || out_ready) && alu_rst_n. On that edge:
  - Register alu_result, alu_zero, alu_cout, alu_overflow and the head tag into out_*.
  - Set out_valid=1 and pop the head.
- Retire without capture: if out_valid && out_ready and count==0, out_valid goes to 0.
- Push and pop on the same edge leave count unchanged.
- Latency: an entry pushed at edge k into an empty FIFO with out_valid=0 is captured at edge k+1. out_valid is high after edge k+1. Throughput is 1 op/cycle under continuous out_ready.
- Holding: while out_valid && !out_ready, all out_* are held and the head stays at the ALU.
- Full: in_ready=0 when count==DEPTH; in_valid is ignored.
- Pointers wrap modulo DEPTH.
- Legal alu_ctrl codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR, 1101 NAND.
  - Any other code is still dispatched to the ALU.
  - At capture, out_illegal=1, out_result=0, and out_zero=out_cout=out_overflow=0.
- sticky_ovf:
  - Set at capture when alu_overflow=1 and the entry is legal.
  - clr_sticky=1 clears it. Set wins over clear on the same edge.

Optional Feature:
- ALU_SEQ_STATS_EN.
- Defined: adds outputs op_count[31:0] and ovf_count[15:0], both reset to 0.
  - op_count increments on each capture.
  - ovf_count increments on each capture with sticky_ovf set-condition true; it saturates at 0xFFFF.
  - op_count wraps from 0xFFFFFFFF to 0.
  - clr_sticky also clears both counters. Increment wins on the same edge.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Push ADD 0x7FFFFFFF+0x00000001, tag 3, out_ready=1 → after 2 edges: out_result=0x80000000, out_overflow=1, out_cout=0, out_tag=3, sticky_ovf=1.
- Push SUB 5-5 → out_result=0, out_zero=1, out_overflow=0. Then clr_sticky=1 → sticky_ovf=0.
- Hold out_ready=0 and push 5 ops with DEPTH=4:
  - Op 1 goes to the output register and ops 2–5 fill the FIFO; in_ready=0 after the 5th accept.
  - Release out_ready → results retire in order, one per cycle, with tags 0..4 matching.
- Push alu_ctrl=0011 with src1=src2=0xFFFFFFFF → out_illegal=1, out_result=0, and sticky_ovf is unchanged.
- Queue 3 ops, then assert rst_n=0 for 1 cycle → out_valid=0, in_ready=1, alu_src1=0, and nothing is retired afterwards. alu_rst_n is 0 after the reset edge and returns to 1 one edge after rst_n=1.
- With ALU_SEQ_STATS_EN, run 10 ops including 2 overflowing ADDs → op_count=10, ovf_count=2.
